// File: rtl/hazard_pkg.sv
// hazard_pkg: shared encodings for the pipeline hazard and forwarding controller
package hazard_pkg;
    typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10} fwd_e;
    typedef enum logic [1:0] {TUSE_ID = 2'd0, TUSE_EX = 2'd1, TUSE_NONE = 2'd3} tuse_e;
    typedef enum logic [1:0] {TNEW_NONE = 2'd0, TNEW_ALU = 2'd1, TNEW_LOAD = 2'd2} tnew_e;
    localparam logic [4:0] REG_ZERO = 5'd0;
    function automatic logic reg_hit(input logic [4:0] dst, input logic [4:0] src);
        return dst == src && dst != REG_ZERO;
    endfunction
endpackage

// File: rtl/hazard_ctrl_md_busy_timer.sv
// md_busy_timer: counts down the mult/div latency so HI/LO users can be held in ID
module md_busy_timer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic busy
);
    logic [3:0] cnt;
    // Load on the ID->EX edge of an md op, otherwise run down to zero
    always_ff @(posedge clk)
        if (reset) cnt <= '0;
        else if (start) cnt <= is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
        else if (cnt != 4'd0) cnt <= cnt - 4'd1;
    assign busy = cnt != 4'd0;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/forward control for the 5-stage pipeline; HAZ_STATS_EN adds stall counters
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic [1:0] id_rs_tuse,
    input  logic [1:0] id_rt_tuse,
    input  logic [4:0] id_dst,
    input  logic [1:0] id_tnew,
    input  logic       id_md_start,
    input  logic       id_md_div,
    input  logic       id_md_use,
    output logic       stall,
    output logic [1:0] ForwardA,
    output logic [1:0] ForwardB,
    output logic       ForwardRsD,
    output logic       ForwardRtD,
    output logic       md_busy
`ifdef HAZ_STATS_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] md_stall_cycles
`endif
);
    logic [4:0] ex_rs, ex_rt, ex_dst, mem_dst, wb_dst;
    logic [1:0] ex_tnew, mem_tnew;
    logic rs_stall, rt_stall, data_stall, md_stall;
    logic mem_ready;

    assign rs_stall = id_rs_tuse != TUSE_NONE &&
        ((reg_hit(ex_dst, id_rs) && ex_tnew > id_rs_tuse) || (reg_hit(mem_dst, id_rs) && mem_tnew > id_rs_tuse));
    assign rt_stall = id_rt_tuse != TUSE_NONE &&
        ((reg_hit(ex_dst, id_rt) && ex_tnew > id_rt_tuse) || (reg_hit(mem_dst, id_rt) && mem_tnew > id_rt_tuse));
    assign data_stall = rs_stall || rt_stall;
    assign md_stall = id_md_use && md_busy;
    assign stall = !reset && (data_stall || md_stall);

    assign mem_ready = mem_tnew == TNEW_NONE;
    assign ForwardA = reg_hit(mem_dst, ex_rs) && mem_ready ? FWD_MEM : reg_hit(wb_dst, ex_rs) ? FWD_WB : FWD_RF;
    assign ForwardB = reg_hit(mem_dst, ex_rt) && mem_ready ? FWD_MEM : reg_hit(wb_dst, ex_rt) ? FWD_WB : FWD_RF;
    assign ForwardRsD = reg_hit(mem_dst, id_rs) && mem_ready;
    assign ForwardRtD = reg_hit(mem_dst, id_rt) && mem_ready;

    // Shadow pipeline: EX takes the ID fields or a bubble, MEM and WB follow behind
    always_ff @(posedge clk)
        if (reset) begin
            {ex_rs, ex_rt, ex_dst, ex_tnew} <= '0;
            mem_dst <= '0;
            mem_tnew <= '0;
            wb_dst <= '0;
        end else begin
            {ex_rs, ex_rt, ex_dst, ex_tnew} <= stall ? '0 : {id_rs, id_rt, id_dst, id_tnew};
            mem_dst <= ex_dst;
            mem_tnew <= ex_tnew != 2'd0 ? ex_tnew - 2'd1 : 2'd0;
            wb_dst <= mem_dst;
        end

    md_busy_timer #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) u_md (
        .clk(clk),
        .reset(reset),
        .start(id_md_start && !stall),
        .is_div(id_md_div),
        .busy(md_busy)
    );

`ifdef HAZ_STATS_EN
    // Stall statistics; an md-only stall is one with no register hazard behind it
    always_ff @(posedge clk)
        if (reset) begin
            stall_cycles <= '0;
            md_stall_cycles <= '0;
        end else begin
            if (stall) stall_cycles <= stall_cycles + 32'd1;
            if (stall && !data_stall) md_stall_cycles <= md_stall_cycles + 32'd1;
        end
`endif
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central hazard and forwarding controller for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB).
- Tracks destination register and result-ready time of in-flight instructions in EX/MEM/WB, using its own shadow pipeline registers.
- Drives the EX operand-mux selects ForwardA/ForwardB and the ID branch-compare forwards.
- Raises stall for load-use, branch-use and mult/div busy hazards; owns the mult/div busy timer.

Parameters:
- MULT_CYCLES, 5: busy cycles after mult/multu enters EX.
- DIV_CYCLES, 10: busy cycles after div/divu enters EX.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_rs_tuse  in  2  cycles until rs is needed: 0=ID (branch), 1=EX, 3=unused.
- id_rt_tuse  in  2  same encoding, for rt.
- id_dst  in  5  destination register of the ID instruction; 0 if none.
- id_tnew  in  2  result-ready time on EX entry: 1=ALU, 2=load, 0=no result.
- id_md_start  in  1  ID instruction is mult/multu/div/divu.
- id_md_div  in  1  qualifies id_md_start: 1=div, 0=mult.
- id_md_use  in  1  ID instruction touches HI/LO (mfhi/mflo/mthi/mtlo/mult/div).
- stall  out  1  hold PC and IF/ID, and bubble ID/EX.
- ForwardA  out  2  EX operand-A mux select.
- ForwardB  out  2  EX operand-B mux select.
- ForwardRsD  out  1  ID compare rs: take MEM ALUResult.
- ForwardRtD  out  1  ID compare rt: take MEM ALUResult.
- md_busy  out  1  mult/div unit busy.

Behaviour:
- Shadow state:
  - EX: ex_rs, ex_rt, ex_dst, ex_tnew.
  - MEM: mem_dst, mem_tnew.
  - WB: wb_dst.
  - Timer: md_cnt[3:0].
  - All zero on reset.
- Reset outputs: stall=0, ForwardA=ForwardB=2'b00, ForwardRsD=ForwardRtD=0, md_busy=0.
  - While reset=1, stall is forced to 0.
  - Reset mid-operation clears all tracking immediately at the next edge, including an in-flight md_cnt.
- Advance each edge:
  - mem <= ex, with mem_tnew = ex_tnew-1, saturating at 0.
  - wb_dst <= mem_dst.
  - If stall=0: ex <= ID fields.
  - If stall=1: EX gets a bubble (all fields 0).
- Stall (combinational), evaluated per source s in {rs, rt} with tuse!=3 and s!=0:
  - stall if ex_dst==s and ex_tnew>tuse;
  - or stall if mem_dst==s and mem_tnew>tuse;
  - or stall if id_md_use=1 and md_busy=1.
- ForwardA select, registered-input compare on ex_rs (ForwardB identical using ex_rt):
  - 2'b10 (MEM ALUResult) if mem_dst==ex_rs, mem_dst!=0 and mem_tnew==0.
  - else 2'b01 (WB WData) if wb_dst==ex_rs and wb_dst!=0.
  - else 2'b00 (RData).
  - MEM has priority over WB. 2'b11 is never driven.
- ForwardRsD/ForwardRtD = mem_dst==id_rs/id_rt, mem_dst!=0, mem_tnew==0.
- Register 0 never matches any hazard or forward comparison.
- Mult/div timer:
  - On an edge with stall=0 and id_md_start=1: md_cnt <= id_md_div ? DIV_CYCLES : MULT_CYCLES.
  - Otherwise md_cnt decrements if nonzero.
  - md_busy = (md_cnt!=0).
  - Because the load happens on the ID→EX edge, md_busy asserts on the first cycle the op is in EX.
  - A back-to-back md op stalls in ID until md_cnt reaches 0.
- Simultaneous load-use and md_busy stall: a single stall; the bubble is inserted once per cycle.

Optional Feature:
- Macro: HAZ_STATS_EN.
- Defined:
  - Adds output stall_cycles[31:0]: counts cycles with stall=1.
  - Cleared by reset; wraps at 2^32.
  - Adds output md_stall_cycles[31:0]: counts cycles where the stall was caused only by md_busy.
- Undefined: neither port nor either counter exists; no other behaviour changes.

Decomposition:
- Shared package hazard_pkg:
  - FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - TUSE_ID=0, TUSE_EX=1, TUSE_NONE=3.
  - TNEW_NONE=0, TNEW_ALU=1, TNEW_LOAD=2.
  - REG_ZERO=5'd0.
- Sub-module md_busy_timer:
  - Inputs: start, is_div. Output: busy.
  - Parameterised by MULT_CYCLES/DIV_CYCLES.
- Stall/forward logic stays in hazard_ctrl.

Test Plan:
- Load-use: lw $8 (tnew=2) then addu using $8 (tuse=1) → stall=1 for exactly 1 cycle; on the next cycle the consumer is in EX with ForwardA=2'b01.
- ALU→ALU: addu $9 then subu rs=$9 → stall=0; ForwardA=2'b10 when subu is in EX. Inserting one nop between them → ForwardA=2'b01.
- Branch after ALU: addu $10 then beq rs=$10 (tuse=0) → stall=1 for 1 cycle, then ForwardRsD=1. Branch after lw → 2 stall cycles.
- $0 writer: addu $0 followed by consumers of $0 → stall=0, all forwards 2'b00.
- div then mfhi: md_busy high for 10 cycles from div's EX cycle; mfhi holds stall=1 throughout, then issues. mult → 5 cycles.
- Reset asserted while md_cnt=4 and a load is in EX → next cycle md_busy=0, stall=0, forwards 2'b00. With HAZ_STATS_EN, stall_cycles=0.
